edge_event_arbiter: RTL

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_event_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/edge_event_arbiter.sv
// Edge detector with per-line pending flags and a round-robin valid/ready event offer.
// Optional falling-edge detection is enabled with EDGE_EVT_FALL_EN.
module edge_event_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 8,
  localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     sig_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IW-1:0]    evt_id,
  output logic             evt_edge,
  output logic [N-1:0]     pending,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic {IDLE, OFFER} state_t;

  localparam logic [31:0] MAXV = 32'((64'd1 << CNT_W) - 64'd1);

  state_t          state;
  logic [N-1:0]    prev;
  logic [N-1:0]    rise;
  logic [N-1:0]    fall;
  logic [N-1:0]    edge_v;
  logic [N-1:0]    acc_mask;
  logic [N-1:0]    drop;
  logic [N-1:0]    req;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   nptr;
  logic [IW-1:0]   win_id;
  logic            win_any;
  logic            acc;
  logic            load;
  logic [31:0]     dsum;
  logic [CNT_W-1:0] cnt_nxt;

  assign rise = sig_in & ~prev;
`ifdef EDGE_EVT_FALL_EN
  assign fall = ~sig_in & prev;
`else
  assign fall = '0;
`endif
  assign edge_v    = rise | fall;
  assign evt_valid = (state == OFFER);
  assign acc       = evt_valid && evt_ready;
  assign nptr      = (evt_id == IW'(N - 1)) ? '0 : evt_id + 1'b1;

  always_comb begin
    acc_mask = '0;
    if (acc) acc_mask[evt_id] = 1'b1;
  end

  // Accepted line is exempt: a new edge there re-arms it instead of dropping.
  assign drop = edge_v & pending & ~acc_mask;
  assign req  = evt_valid ? (pending & ~acc_mask) : pending;
  assign load = win_any && (!evt_valid || evt_ready);

  always_comb begin
    int start;
    int idx;
    start   = evt_valid ? int'(nptr) : int'(ptr);
    idx     = 0;
    win_any = 1'b0;
    win_id  = '0;
    // Walk backwards so the lowest offset from start wins last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = start + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        win_any = 1'b1;
        win_id  = IW'(idx);
      end
    end
  end

  always_comb begin
    dsum = 32'(drop_cnt);
    for (int i = 0; i < N; i++) dsum = dsum + 32'(drop[i]);
    cnt_nxt = (dsum > MAXV) ? CNT_W'(MAXV) : CNT_W'(dsum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '0;
      pending  <= '0;
      state    <= IDLE;
      evt_id   <= '0;
      ptr      <= '0;
      drop_cnt <= '0;
    end else begin
      prev     <= sig_in;
      pending  <= (pending & ~acc_mask) | edge_v;
      drop_cnt <= cnt_nxt;
      if (load) evt_id <= win_id;
      if (acc) ptr <= nptr;
      unique case (state)
        IDLE:    if (win_any) state <= OFFER;
        OFFER:   if (evt_ready && !win_any) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EDGE_EVT_FALL_EN
  logic [N-1:0] pending_edge;
  logic         edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_edge <= '0;
      edge_q       <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++)
        if (edge_v[i] && !drop[i]) pending_edge[i] <= rise[i];
      if (load) edge_q <= pending_edge[win_id];
    end
  end

  assign evt_edge = edge_q;
`else
  assign evt_edge = 1'b1;
`endif

endmodule
